// File: rtl/pong_input_pkg.sv
// Shared types and constants for the joystick input path.
package pong_input_pkg;

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } deb_state_e;

    // Raw pin level when the stick is not pushed, for active-low wiring.
    localparam logic RawReleasedActiveLow = 1'b1;

    // 10 ms at 25 MHz.
    localparam int unsigned DefaultDebounceCycles = 250000;

endpackage

// File: rtl/debounce_channel.sv
// One joystick direction: 2-flop synchroniser, polarity normalisation, debounce FSM.
module debounce_channel
    import pong_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_W           = 18,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic db_d_o,
    output logic pulse_o
);

    if ((DEBOUNCE_CYCLES < 1) || (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W))) begin : gen_cfg_err
        $error("debounce_channel: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    localparam logic RelLevel = RAW_ACTIVE_LOW ? RawReleasedActiveLow : ~RawReleasedActiveLow;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             pressed;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    assign pressed = RAW_ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            StReleased: begin
                if (pressed) begin
                    state_d = StPressPend;
                    cnt_d   = '0;
                end
            end
            StPressPend: begin
                if (!pressed) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!pressed) begin
                    state_d = StReleasePend;
                    cnt_d   = '0;
                end
            end
            StReleasePend: begin
                if (pressed) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= RelLevel;
            sync2_q <= RelLevel;
            state_q <= StReleased;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state level so the top can register outputs on the same edge as the FSM.
    assign db_d_o  = (state_d == StPressed) || (state_d == StReleasePend);
    assign pulse_o = pulse_q;

endmodule

// File: rtl/joystick_conditioner.sv
// Per-player joystick front end: two debounced channels feeding the paddle's
// active-low controls, press pulses and a conflict flag.
module joystick_conditioner
    import pong_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_W           = 18,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    output logic control_up,
    output logic control_down,
    output logic press_up_pulse,
    output logic press_down_pulse,
    output logic conflict
);

    logic up_db_d, down_db_d;
    logic ctrl_up_q, ctrl_down_q, conflict_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_up (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (raw_up),
        .db_d_o (up_db_d),
        .pulse_o(press_up_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_down (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (raw_down),
        .db_d_o (down_db_d),
        .pulse_o(press_down_pulse)
    );

    // Both pressed: release both controls so the paddle stops instead of picking a side.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_up_q   <= 1'b1;
            ctrl_down_q <= 1'b1;
            conflict_q  <= 1'b0;
        end else begin
            ctrl_up_q   <= ~(up_db_d & ~down_db_d);
            ctrl_down_q <= ~(down_db_d & ~up_db_d);
            conflict_q  <= up_db_d & down_db_d;
        end
    end

    assign control_up   = ctrl_up_q;
    assign control_down = ctrl_down_q;
    assign conflict     = conflict_q;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
module tb_joystick_conditioner;

    logic clock;
    logic reset;
    logic raw_up;
    logic raw_down;
    logic control_up;
    logic control_down;
    logic press_up_pulse;
    logic press_down_pulse;
    logic conflict;

    int checks = 0;
    int errors = 0;

    // {control_up, control_down, press_up_pulse, press_down_pulse, conflict}
    logic [4:0] obs;
    assign obs = {control_up, control_down, press_up_pulse, press_down_pulse, conflict};

    joystick_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (18),
        .RAW_ACTIVE_LOW (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .raw_up          (raw_up),
        .raw_down        (raw_down),
        .control_up      (control_up),
        .control_down    (control_down),
        .press_up_pulse  (press_up_pulse),
        .press_down_pulse(press_down_pulse),
        .conflict        (conflict)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        exp = 5'b11000;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            raw_up   = 1'($urandom_range(0, 1));
            raw_down = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
        reset    = 1'b0;
        raw_up   = 1'b1;
        raw_down = 1'b1;
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_after: got %b expected %b", obs, exp);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_clean_press();
        logic [4:0] exp;
        raw_up = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {(i >= 6) ? 1'b0 : 1'b1, 1'b1, (i == 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clean_press edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        raw_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {(i >= 6) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clean_release edge%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] exp;
        logic [15:0] pattern;
        // Raw level per edge: low 4, high 1, low 3, then high.
        pattern = 16'b1111_1111_0001_0000;
        for (int i = 0; i < 16; i++) begin
            raw_up = pattern[i];
            tick();
            exp = 5'b11000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        // Exactly DEBOUNCE_CYCLES+1 low cycles is the shortest accepted press.
        for (int i = 0; i < 16; i++) begin
            raw_up = (i < 5) ? 1'b0 : 1'b1;
            tick();
            exp = {(i >= 6 && i < 11) ? 1'b0 : 1'b1, 1'b1, (i == 6), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce_final edge%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_conflict();
        logic [4:0] exp;
        raw_up = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        exp = 5'b01000;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL conflict_up_held: got %b expected %b", obs, exp);
        end
        raw_down = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i < 6) ? 5'b01000 : {1'b1, 1'b1, 1'b0, (i == 6), 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL conflict_down edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        raw_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i < 6) ? 5'b11001 : 5'b10000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL conflict_release_up edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        raw_down = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        exp = 5'b11000;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL conflict_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [4:0] exp;
        raw_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = 5'b11000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_pre edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        reset = 1'b1;
        tick();
        exp = 5'b11000;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL midrst_reset: got %b expected %b", obs, exp);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = {1'b1, (i >= 6) ? 1'b0 : 1'b1, 1'b0, (i == 6), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_restart edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        raw_down = 1'b1;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp;
        raw_up   = 1'b0;
        raw_down = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = {1'b1, 1'b1, (i == 6), (i == 6), (i >= 6)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL simultaneous edge%0d: got %b expected %b", i, obs, exp);
            end
        end
        raw_up   = 1'b1;
        raw_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = {1'b1, 1'b1, 1'b0, 1'b0, (i < 6)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL simultaneous_release edge%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        raw_up   = 1'b1;
        raw_down = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_conflict();
        test_reset_mid_debounce();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
